// File: rtl/tetron_move_ctrl_pkg.sv
// Shared types for the tetromino move controller.
// Commands, FSM states, coordinate widths, board defaults.
package tetron_move_ctrl_pkg;

  localparam int DEF_ROWS = 20;
  localparam int DEF_COLS = 10;
  localparam int ROW_W    = 5;
  localparam int COL_W    = 4;
  localparam int OFF_W    = 5;
  localparam int ABS_W    = 6;

  typedef enum logic [1:0] {
    CMD_LEFT  = 2'd0,
    CMD_RIGHT = 2'd1,
    CMD_ROT   = 2'd2,
    CMD_DOWN  = 2'd3
  } cmd_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SHAPE,
    S_WAIT,
    S_CHK0,
    S_CHK1,
    S_CHK2,
    S_CHK3,
    S_RESOLVE,
    S_LOCK0,
    S_LOCK1,
    S_LOCK2,
    S_LOCK3
  } state_e;

  typedef struct packed {
    logic [OFF_W-1:0] v;
    logic [OFF_W-1:0] h;
  } off_t;

endpackage

// File: rtl/tetron_cell_check.sv
// Origin + signed block offset -> absolute cell and bounds flag.
// Ports: org_row/org_col (6b two's compl), voff/hoff (5b signed),
// abs_row/abs_col (cell address), oob (cell off the board).
module tetron_cell_check
  import tetron_move_ctrl_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic [ABS_W-1:0] org_row,
  input  logic [ABS_W-1:0] org_col,
  input  logic [OFF_W-1:0] voff,
  input  logic [OFF_W-1:0] hoff,
  output logic [ROW_W-1:0] abs_row,
  output logic [COL_W-1:0] abs_col,
  output logic             oob
);

  logic [ABS_W-1:0] r;
  logic [ABS_W-1:0] c;

  // 6-bit two's complement sum: -1 stays negative
  // instead of wrapping to 31/15.
  always_comb begin
    r       = org_row + {voff[OFF_W-1], voff};
    c       = org_col + {hoff[OFF_W-1], hoff};
    abs_row = r[ROW_W-1:0];
    abs_col = c[COL_W-1:0];
    oob     = r[ABS_W-1]
            | (r[ABS_W-2:0] > 5'(ROWS - 1))
            | c[ABS_W-1]
            | (c[ABS_W-2:0] > 5'(COLS - 1));
  end

endmodule

// File: rtl/tetron_move_ctrl.sv
// Live tetromino sequencer: spawn, move, rotate, drop, lock.
// Ports: spawn/cmd_valid/cmd in, cmd_ready out; shp_* to shaper,
// blk*_offset back; brd_rd_* / brd_wr_* board ports; pos_*,
// piece_live, done, accepted, locked, game_over status.
module tetron_move_ctrl
  import tetron_move_ctrl_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int SPAWN_ROW = 1,
  parameter int SPAWN_COL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spawn,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  output logic             shp_active,
  output logic [2:0]       shp_rot,
  input  logic [OFF_W-1:0] blk1_voffset,
  input  logic [OFF_W-1:0] blk1_hoffset,
  input  logic [OFF_W-1:0] blk2_voffset,
  input  logic [OFF_W-1:0] blk2_hoffset,
  input  logic [OFF_W-1:0] blk3_voffset,
  input  logic [OFF_W-1:0] blk3_hoffset,
  input  logic [OFF_W-1:0] blk4_voffset,
  input  logic [OFF_W-1:0] blk4_hoffset,
  output logic [ROW_W-1:0] brd_rd_row,
  output logic [COL_W-1:0] brd_rd_col,
  output logic             brd_rd_en,
  input  logic             brd_rd_data,
  output logic             brd_wr_en,
  output logic [ROW_W-1:0] brd_wr_row,
  output logic [COL_W-1:0] brd_wr_col,
  output logic [ROW_W-1:0] pos_row,
  output logic [COL_W-1:0] pos_col,
  output logic [1:0]       pos_rot,
  output logic             piece_live,
  output logic             done,
  output logic             accepted,
  output logic             locked,
  output logic             game_over
);

  state_e           state_q, state_d;
  logic [ABS_W-1:0] cand_row_q, cand_row_d;
  logic [ABS_W-1:0] cand_col_q, cand_col_d;
  logic [1:0]       cand_rot_q, cand_rot_d;
  logic             op_spawn_q, op_spawn_d;
  cmd_e             cmd_q, cmd_d;
  logic             hit_q, hit_d;
  logic             rd_pend_q, rd_pend_d;
  off_t [3:0]       off_q, off_d;
  logic [ROW_W-1:0] pos_row_q, pos_row_d;
  logic [COL_W-1:0] pos_col_q, pos_col_d;
  logic [1:0]       pos_rot_q, pos_rot_d;
  logic             live_q, live_d;
  logic             done_q, done_d;
  logic             acc_q, acc_d;
  logic             locked_q, locked_d;
  logic             go_q, go_d;

  logic [1:0]       idx;
  logic             lock_sel;
  logic [ABS_W-1:0] org_row, org_col;
  logic [ROW_W-1:0] abs_row;
  logic [COL_W-1:0] abs_col;
  logic             oob;
  logic             rd_en, wr_en, hit_now, hit_all;

  // One cell checker serves both the collision scan (candidate
  // pose) and the lock writes (committed pose).
  always_comb begin
    idx      = 2'd0;
    lock_sel = 1'b0;
    unique case (state_q)
      S_CHK1:  idx = 2'd1;
      S_CHK2:  idx = 2'd2;
      S_CHK3:  idx = 2'd3;
      S_LOCK0: lock_sel = 1'b1;
      S_LOCK1: begin idx = 2'd1; lock_sel = 1'b1; end
      S_LOCK2: begin idx = 2'd2; lock_sel = 1'b1; end
      S_LOCK3: begin idx = 2'd3; lock_sel = 1'b1; end
      default: ;
    endcase
    org_row = lock_sel ? ABS_W'(pos_row_q) : cand_row_q;
    org_col = lock_sel ? ABS_W'(pos_col_q) : cand_col_q;
  end

  tetron_cell_check #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_cell (
    .org_row (org_row),
    .org_col (org_col),
    .voff    (off_q[idx].v),
    .hoff    (off_q[idx].h),
    .abs_row (abs_row),
    .abs_col (abs_col),
    .oob     (oob)
  );

  always_comb begin
    state_d    = state_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    cand_rot_d = cand_rot_q;
    op_spawn_d = op_spawn_q;
    cmd_d      = cmd_q;
    hit_d      = hit_q;
    off_d      = off_q;
    pos_row_d  = pos_row_q;
    pos_col_d  = pos_col_q;
    pos_rot_d  = pos_rot_q;
    live_d     = live_q;
    go_d       = go_q;
    done_d     = 1'b0;
    acc_d      = 1'b0;
    locked_d   = 1'b0;
    shp_active = 1'b0;
    shp_rot    = 3'd0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    cmd_ready  = (state_q == S_IDLE) & live_q & ~go_q;
    // Read data belongs to the read issued last cycle.
    hit_now    = rd_pend_q & brd_rd_data;
    hit_all    = hit_q | hit_now;
    unique case (state_q)
      S_IDLE: begin
        if (spawn && !live_q && !go_q) begin
          cand_row_d = ABS_W'(SPAWN_ROW);
          cand_col_d = ABS_W'(SPAWN_COL);
          cand_rot_d = 2'd0;
          op_spawn_d = 1'b1;
          hit_d      = 1'b0;
          state_d    = S_SHAPE;
        end else if (cmd_valid && cmd_ready) begin
          cand_row_d = ABS_W'(pos_row_q);
          cand_col_d = ABS_W'(pos_col_q);
          cand_rot_d = pos_rot_q;
          op_spawn_d = 1'b0;
          cmd_d      = cmd_e'(cmd);
          hit_d      = 1'b0;
          unique case (cmd_e'(cmd))
            CMD_LEFT:  cand_col_d = ABS_W'(pos_col_q) - 6'd1;
            CMD_RIGHT: cand_col_d = ABS_W'(pos_col_q) + 6'd1;
            CMD_ROT:   cand_rot_d = pos_rot_q + 2'd1;
            CMD_DOWN:  cand_row_d = ABS_W'(pos_row_q) + 6'd1;
          endcase
          state_d = S_SHAPE;
        end
      end
      S_SHAPE: begin
        shp_active = 1'b1;
        shp_rot    = {1'b0, cand_rot_q};
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        off_d[0] = {blk1_voffset, blk1_hoffset};
        off_d[1] = {blk2_voffset, blk2_hoffset};
        off_d[2] = {blk3_voffset, blk3_hoffset};
        off_d[3] = {blk4_voffset, blk4_hoffset};
        state_d  = S_CHK0;
      end
      S_CHK0, S_CHK1, S_CHK2, S_CHK3: begin
        rd_en = ~oob;
        hit_d = hit_all | oob;
        unique case (state_q)
          S_CHK0:  state_d = S_CHK1;
          S_CHK1:  state_d = S_CHK2;
          S_CHK2:  state_d = S_CHK3;
          default: state_d = S_RESOLVE;
        endcase
      end
      S_RESOLVE: begin
        done_d  = 1'b1;
        acc_d   = ~hit_all;
        state_d = S_IDLE;
        if (!hit_all) begin
          pos_row_d = cand_row_q[ROW_W-1:0];
          pos_col_d = cand_col_q[COL_W-1:0];
          pos_rot_d = cand_rot_q;
        end
        if (op_spawn_q) begin
          live_d = ~hit_all;
          go_d   = go_q | hit_all;
        end else if (hit_all && cmd_q == CMD_DOWN) begin
          state_d = S_LOCK0;
        end
      end
      S_LOCK0: begin wr_en = 1'b1; state_d = S_LOCK1; end
      S_LOCK1: begin wr_en = 1'b1; state_d = S_LOCK2; end
      S_LOCK2: begin wr_en = 1'b1; state_d = S_LOCK3; end
      S_LOCK3: begin
        wr_en    = 1'b1;
        locked_d = 1'b1;
        live_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rd_pend_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cand_row_q <= '0;
      cand_col_q <= '0;
      cand_rot_q <= '0;
      op_spawn_q <= 1'b0;
      cmd_q      <= CMD_LEFT;
      hit_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      off_q      <= '0;
      pos_row_q  <= ROW_W'(SPAWN_ROW);
      pos_col_q  <= COL_W'(SPAWN_COL);
      pos_rot_q  <= 2'd0;
      live_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= 1'b0;
      locked_q   <= 1'b0;
      go_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      cand_rot_q <= cand_rot_d;
      op_spawn_q <= op_spawn_d;
      cmd_q      <= cmd_d;
      hit_q      <= hit_d;
      rd_pend_q  <= rd_pend_d;
      off_q      <= off_d;
      pos_row_q  <= pos_row_d;
      pos_col_q  <= pos_col_d;
      pos_rot_q  <= pos_rot_d;
      live_q     <= live_d;
      done_q     <= done_d;
      acc_q      <= acc_d;
      locked_q   <= locked_d;
      go_q       <= go_d;
    end
  end

  assign brd_rd_en  = rd_en;
  assign brd_rd_row = rd_en ? abs_row : '0;
  assign brd_rd_col = rd_en ? abs_col : '0;
  assign brd_wr_en  = wr_en;
  assign brd_wr_row = wr_en ? abs_row : '0;
  assign brd_wr_col = wr_en ? abs_col : '0;
  assign pos_row    = pos_row_q;
  assign pos_col    = pos_col_q;
  assign pos_rot    = pos_rot_q;
  assign piece_live = live_q;
  assign done       = done_q;
  assign accepted   = acc_q;
  assign locked     = locked_q;
  assign game_over  = go_q;

endmodule

// File: tb/tb_tetron_move_ctrl.sv
// Scoreboard bench for tetron_move_ctrl with an S-piece shaper
// and a 20x10 board model.
module tb_tetron_move_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spawn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic       cmd_ready, shp_active;
  logic [2:0] shp_rot;
  logic [4:0] bv [4];
  logic [4:0] bh [4];
  logic [4:0] brd_rd_row, brd_wr_row, pos_row;
  logic [3:0] brd_rd_col, brd_wr_col, pos_col;
  logic       brd_rd_en, brd_wr_en;
  logic       brd_rd_data = 1'b0;
  logic [1:0] pos_rot;
  logic       piece_live, done, accepted, locked, game_over;

  tetron_move_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .spawn        (spawn),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .cmd_ready    (cmd_ready),
    .shp_active   (shp_active),
    .shp_rot      (shp_rot),
    .blk1_voffset (bv[0]),
    .blk1_hoffset (bh[0]),
    .blk2_voffset (bv[1]),
    .blk2_hoffset (bh[1]),
    .blk3_voffset (bv[2]),
    .blk3_hoffset (bh[2]),
    .blk4_voffset (bv[3]),
    .blk4_hoffset (bh[3]),
    .brd_rd_row   (brd_rd_row),
    .brd_rd_col   (brd_rd_col),
    .brd_rd_en    (brd_rd_en),
    .brd_rd_data  (brd_rd_data),
    .brd_wr_en    (brd_wr_en),
    .brd_wr_row   (brd_wr_row),
    .brd_wr_col   (brd_wr_col),
    .pos_row      (pos_row),
    .pos_col      (pos_col),
    .pos_rot      (pos_rot),
    .piece_live   (piece_live),
    .done         (done),
    .accepted     (accepted),
    .locked       (locked),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // S piece: rot 0/2 vertical, rot 1/3 horizontal
  int sv [4][4] = '{'{0, -1, 0, 1}, '{0, 0, 1, 1},
                    '{0, -1, 0, 1}, '{0, 0, 1, 1}};
  int sh [4][4] = '{'{0, 0, -1, -1}, '{0, 1, -1, 0},
                    '{0, 0, -1, -1}, '{0, 1, -1, 0}};

  // registered shaper
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        bv[i] <= 5'd0;
        bh[i] <= 5'd0;
      end else if (shp_active) begin
        bv[i] <= 5'(sv[shp_rot[1:0]][i]);
        bh[i] <= 5'(sh[shp_rot[1:0]][i]);
      end
    end
  end

  // environment board: 1-cycle read, write on lock strobe
  bit   env [20][10];
  logic clr_b = 1'b0;
  logic pre_en = 1'b0;
  int   pre_r = 0;
  int   pre_c = 0;
  always @(posedge clk) begin
    if (clr_b) begin
      for (int r = 0; r < 20; r++)
        for (int c = 0; c < 10; c++) env[r][c] <= 1'b0;
    end else begin
      if (pre_en) env[pre_r][pre_c] <= 1'b1;
      if (brd_wr_en && brd_wr_row < 20 && brd_wr_col < 10)
        env[brd_wr_row][brd_wr_col] <= 1'b1;
    end
    if (brd_rd_en)
      brd_rd_data <= (brd_rd_row < 20 && brd_rd_col < 10) ?
                     env[brd_rd_row][brd_rd_col] : 1'b0;
  end

  typedef struct {
    int r;
    int c;
  } cell_t;
  typedef struct {
    bit acc;
    int row;
    int col;
    int rot;
    bit live;
    bit go;
    int cyc;
  } exp_t;

  cell_t rdq [$];
  cell_t wrq [$];
  exp_t  expq [$];
  int    lockq [$];
  int    errors = 0;
  int    checks = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  // monitor
  cell_t ce;
  exp_t  ee;
  int    lc;
  always @(negedge clk) begin
    if (!rst) begin
      if (brd_rd_en) begin
        if (rdq.size() == 0) chk("unexpected_rd", 1, 0);
        else begin
          ce = rdq.pop_front();
          chk("rd_row", int'(brd_rd_row), ce.r);
          chk("rd_col", int'(brd_rd_col), ce.c);
        end
      end
      if (brd_wr_en) begin
        if (wrq.size() == 0) chk("unexpected_wr", 1, 0);
        else begin
          ce = wrq.pop_front();
          chk("wr_row", int'(brd_wr_row), ce.r);
          chk("wr_col", int'(brd_wr_col), ce.c);
        end
      end
      if (done) begin
        if (expq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          ee = expq.pop_front();
          chk("done_cycle", cyc, ee.cyc);
          chk("accepted", int'(accepted), int'(ee.acc));
          chk("pos_row", int'(pos_row), ee.row);
          chk("pos_col", int'(pos_col), ee.col);
          chk("pos_rot", int'(pos_rot), ee.rot);
          chk("piece_live", int'(piece_live), int'(ee.live));
          chk("game_over", int'(game_over), int'(ee.go));
        end
      end
      if (locked) begin
        if (lockq.size() == 0) chk("unexpected_lock", 1, 0);
        else begin
          lc = lockq.pop_front();
          chk("locked_cycle", cyc, lc);
          chk("locked_live", int'(piece_live), 0);
          chk("lock_writes_left", wrq.size(), 0);
        end
      end
    end
  end

  // reference model
  int m_row, m_col, m_rot;
  bit m_live, m_go;
  bit mb [20][10];

  function automatic bit inb(int r, int c);
    return r >= 0 && r < 20 && c >= 0 && c < 10;
  endfunction

  function automatic bit fits(int r, int c, int rot);
    bit ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!inb(r + sv[rot][i], c + sh[rot][i])) ok = 1'b0;
      else if (mb[r + sv[rot][i]][c + sh[rot][i]]) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic void push_reads(int r, int c, int rot);
    for (int i = 0; i < 4; i++)
      if (inb(r + sv[rot][i], c + sh[rot][i]))
        rdq.push_back('{r + sv[rot][i], c + sh[rot][i]});
  endfunction

  function automatic void model_reset();
    m_row = 1; m_col = 4; m_rot = 0;
    m_live = 1'b0; m_go = 1'b0;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) mb[r][c] = 1'b0;
    rdq.delete(); wrq.delete(); expq.delete(); lockq.delete();
  endfunction

  task automatic wait_quiet(int max);
    int n = 0;
    while ((expq.size() + rdq.size() + wrq.size() + lockq.size()) > 0
           && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) begin
      chk("timeout_pending",
          expq.size() + rdq.size() + wrq.size() + lockq.size(), 0);
      rdq.delete(); wrq.delete(); expq.delete(); lockq.delete();
    end
    @(negedge clk);
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst = 1'b1;
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_vals();
    chk("rv_cmd_ready", int'(cmd_ready), 0);
    chk("rv_shp_active", int'(shp_active), 0);
    chk("rv_shp_rot", int'(shp_rot), 0);
    chk("rv_rd_en", int'(brd_rd_en), 0);
    chk("rv_rd_row", int'(brd_rd_row), 0);
    chk("rv_rd_col", int'(brd_rd_col), 0);
    chk("rv_wr_en", int'(brd_wr_en), 0);
    chk("rv_wr_row", int'(brd_wr_row), 0);
    chk("rv_wr_col", int'(brd_wr_col), 0);
    chk("rv_pos_row", int'(pos_row), 1);
    chk("rv_pos_col", int'(pos_col), 4);
    chk("rv_pos_rot", int'(pos_rot), 0);
    chk("rv_live", int'(piece_live), 0);
    chk("rv_done", int'(done), 0);
    chk("rv_accepted", int'(accepted), 0);
    chk("rv_locked", int'(locked), 0);
    chk("rv_game_over", int'(game_over), 0);
  endtask

  task automatic preload(int r, int c);
    @(negedge clk);
    pre_r = r;
    pre_c = c;
    pre_en = 1'b1;
    mb[r][c] = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic do_spawn();
    int k;
    bit ok;
    @(negedge clk);
    k = cyc;
    if (!m_live && !m_go) begin
      ok = fits(1, 4, 0);
      push_reads(1, 4, 0);
      if (ok) begin
        m_row = 1; m_col = 4; m_rot = 0; m_live = 1'b1;
      end else m_go = 1'b1;
      expq.push_back('{ok, m_row, m_col, m_rot, m_live, m_go, k + 8});
      spawn = 1'b1;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd = 2'($urandom_range(0, 3));
      @(negedge clk);
      spawn = 1'b0;
      cmd_valid = 1'b0;
      wait_quiet(40);
    end else begin
      spawn = 1'b1;
      @(negedge clk);
      spawn = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic do_cmd(int c);
    int k, nr, nc, nrot;
    bit rdy, ok;
    @(negedge clk);
    k = cyc;
    rdy = m_live && !m_go;
    chk("cmd_ready", int'(cmd_ready), int'(rdy));
    cmd_valid = 1'b1;
    cmd = 2'(c);
    if (rdy) begin
      nr = m_row; nc = m_col; nrot = m_rot;
      case (c)
        0: nc = nc - 1;
        1: nc = nc + 1;
        2: nrot = (nrot + 1) % 4;
        default: nr = nr + 1;
      endcase
      ok = fits(nr, nc, nrot);
      push_reads(nr, nc, nrot);
      if (ok) begin
        m_row = nr; m_col = nc; m_rot = nrot;
      end
      expq.push_back('{ok, m_row, m_col, m_rot, m_live, m_go, k + 8});
      if (!ok && c == 3) begin
        for (int i = 0; i < 4; i++) begin
          wrq.push_back('{m_row + sv[m_rot][i], m_col + sh[m_rot][i]});
          mb[m_row + sv[m_rot][i]][m_col + sh[m_rot][i]] = 1'b1;
        end
        lockq.push_back(k + 12);
        m_live = 1'b0;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    if (rdy) wait_quiet(40);
    else repeat (10) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, x;
    model_reset();
    reset_all();
    chk_reset_vals();

    // spawn on empty board, walk to the left wall, bump it
    do_spawn();
    do_cmd(0);
    do_cmd(0);
    do_cmd(0);
    do_cmd(0);
    chk("left_wall_col", int'(pos_col), 1);
    // rotate 0->1->2->3->0
    for (int i = 0; i < 4; i++) do_cmd(2);
    chk("rot_wrap", int'(pos_rot), 0);

    // full row 3, drop from row 1 -> lock
    reset_all();
    for (int c = 0; c < 10; c++) preload(3, c);
    do_spawn();
    do_cmd(3);
    chk("after_lock_live", int'(piece_live), 0);
    do_cmd(1);

    // blocked spawn -> game over, then everything ignored
    reset_all();
    preload(1, 4);
    do_spawn();
    do_spawn();
    do_cmd(3);
    chk("go_sticky", int'(game_over), 1);

    // reset in the middle of the collision scan (CHK2)
    reset_all();
    @(negedge clk);
    k = cyc;
    push_reads(1, 4, 0);
    spawn = 1'b1;
    @(negedge clk);
    spawn = 1'b0;
    while (cyc < k + 5) @(negedge clk);
    #2;
    chk("reads_before_rst", rdq.size(), 1);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    repeat (12) @(negedge clk);
    do_spawn();

    // randomized episodes
    for (int ep = 0; ep < 6; ep++) begin
      reset_all();
      x = $urandom_range(0, 12);
      for (int j = 0; j < x; j++)
        preload($urandom_range(4, 19), $urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0)
        preload($urandom_range(0, 2), $urandom_range(3, 4));
      do_spawn();
      for (int op = 0; op < 40; op++) begin
        x = $urandom_range(0, 99);
        if (x < 10) do_spawn();
        else if (x < 30) do_cmd(0);
        else if (x < 50) do_cmd(1);
        else if (x < 65) do_cmd(2);
        else do_cmd(3);
      end
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
